// File: rtl/audio_mix_sdac_pkg.sv
// Shared types and helpers for the audio mixer / sigma-delta DAC slice.
// Holds the mixer FSM state type and the unsigned saturation helper.
package audio_pkg;

    localparam int SHIFT_W   = 3;
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mix_state_t;

    // Clamp an unsigned value to the largest number representable in 'width' bits.
    function automatic logic [SAT_MAX_W-1:0] sat_u(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
        logic [SAT_MAX_W-1:0] max_v;
        max_v = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        if (value > max_v) begin
            sat_u = max_v;
        end else begin
            sat_u = value;
        end
    endfunction

endpackage

// File: rtl/audio_mix_sdac_if.sv
// Sample/control/status bundle between a sound core and the audio mixer.
// The mixer takes the slave view; the sound core (or a bench) takes the master view.
interface audio_mix_sdac_if #(
    parameter int NCH   = 3,
    parameter int IN_W  = 8,
    parameter int OUT_W = 11
) ();

    logic                  ce_sample;
    logic [NCH*IN_W-1:0]   ch_in;
    logic [NCH-1:0]        ch_mute;
    logic                  clr_flags;
    logic [OUT_W-1:0]      mix_out;
    logic                  mix_valid;
    logic                  busy;
    logic                  clip;
    logic                  overrun;
    logic                  dac_o;

    modport master (
        output ce_sample, ch_in, ch_mute, clr_flags,
        input  mix_out, mix_valid, busy, clip, overrun, dac_o
    );

    modport slave (
        input  ce_sample, ch_in, ch_mute, clr_flags,
        output mix_out, mix_valid, busy, clip, overrun, dac_o
    );

endinterface

// File: rtl/audio_mix_sdac_sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry out of a W-bit phase accumulator
// forms a 1-bit stream whose density of ones is din / 2^W.
module sigma_delta_dac #(
    parameter int W = 11
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W:0] acc_r;
    logic       dout_r;

    // Accumulate the input every clock; the carry bit becomes the registered output.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_r  <= '0;
            dout_r <= 1'b0;
        end else begin
            acc_r  <= {1'b0, acc_r[W-1:0]} + {1'b0, din};
            dout_r <= acc_r[W];
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/audio_mix_sdac.sv
// Sequential NCH-channel weighted mixer with saturation, sticky clip/overrun
// flags, and a sigma-delta 1-bit DAC on the mixed sample.
module audio_mix_sdac
    import audio_pkg::*;
#(
    parameter int                       NCH      = 3,
    parameter int                       IN_W     = 8,
    parameter int                       OUT_W    = 11,
    parameter logic [NCH*SHIFT_W-1:0]   CH_SHIFT = {3'd1, 3'd2, 3'd0}
) (
    input  logic             clk_sys,
    input  logic             reset,
    audio_mix_sdac_if.slave  bus
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    // Wide enough for NCH channels each shifted by up to 7, so the sum never wraps.
    localparam int SUM_W = IN_W + 7 + $clog2(NCH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    if (NCH < 1 || NCH > 16 || OUT_W < IN_W || SUM_W > SAT_MAX_W) begin : g_param_err
        $error("audio_mix_sdac: illegal parameter combination");
    end

    mix_state_t            state_r;
    mix_state_t            state_s;
    logic [NCH*IN_W-1:0]   ch_snap_r;
    logic [NCH-1:0]        mute_snap_r;
    logic [IDX_W-1:0]      idx_r;
    logic [SUM_W-1:0]      sum_r;
    logic                  accept_s;
    logic                  last_s;
    logic                  ovr_evt_s;
    logic                  clip_evt_s;
    logic [IN_W-1:0]       sample_s;
    logic [SHIFT_W-1:0]    shift_s;
    logic [SUM_W-1:0]      term_s;
    logic [SUM_W-1:0]      sum_next_s;
    logic [SAT_MAX_W-1:0]  sat_s;
    logic [OUT_W-1:0]      mix_out_r;
    logic                  mix_valid_r;
    logic                  busy_r;
    logic                  clip_r;
    logic                  overrun_r;
    logic                  dac_s;

    // Mixer FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE accepts a new strobe exactly like IDLE.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        last_s    = 1'b0;
        ovr_evt_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.ce_sample) begin
                    accept_s = 1'b1;
                    state_s  = ACCUM;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCUM: begin
                ovr_evt_s = bus.ce_sample;
                if (idx_r == LAST_IDX) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = ACCUM;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Weighted term for the current channel and the saturated running total.
    always_comb begin
        sample_s = ch_snap_r[IN_W*idx_r +: IN_W];
        shift_s  = CH_SHIFT[SHIFT_W*idx_r +: SHIFT_W];
        if (mute_snap_r[idx_r]) begin
            term_s = '0;
        end else begin
            term_s = SUM_W'(sample_s) << shift_s;
        end
        sum_next_s = sum_r + term_s;
        sat_s      = sat_u(SAT_MAX_W'(sum_next_s), OUT_W);
        clip_evt_s = last_s && (sat_s != SAT_MAX_W'(sum_next_s));
    end

    // Snapshot, accumulation and the registered result/status outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ch_snap_r   <= '0;
            mute_snap_r <= '0;
            idx_r       <= '0;
            sum_r       <= '0;
            mix_out_r   <= '0;
            mix_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            clip_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                ch_snap_r   <= bus.ch_in;
                mute_snap_r <= bus.ch_mute;
                idx_r       <= '0;
                sum_r       <= '0;
            end else if (state_r == ACCUM) begin
                idx_r <= idx_r + IDX_W'(1);
                sum_r <= sum_next_s;
            end
            if (last_s) begin
                mix_out_r <= sat_s[OUT_W-1:0];
            end
            mix_valid_r <= last_s;
            busy_r      <= (state_s == ACCUM);
            // A flag event in the same cycle as a clear keeps the flag set.
            clip_r      <= clip_evt_s | (clip_r & ~bus.clr_flags);
            overrun_r   <= ovr_evt_s  | (overrun_r & ~bus.clr_flags);
        end
    end

    sigma_delta_dac #(
        .W (OUT_W)
    ) u_sdac (
        .clk_sys (clk_sys),
        .reset   (reset),
        .din     (mix_out_r),
        .dout    (dac_s)
    );

    assign bus.mix_out   = mix_out_r;
    assign bus.mix_valid = mix_valid_r;
    assign bus.busy      = busy_r;
    assign bus.clip      = clip_r;
    assign bus.overrun   = overrun_r;
    assign bus.dac_o     = dac_s;

endmodule

// File: tb/tb_audio_mix_sdac.sv
// Self-checking bench: two mixers (OUT_W=11 and OUT_W=10) run in lockstep on the
// same inputs and are compared against an arithmetic reference model.
module tb_audio_mix_sdac;

    localparam int NCH = 3;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    logic clip_a_m = 1'b0;
    logic clip_b_m = 1'b0;
    logic ovr_m    = 1'b0;

    // Channel a weight x1, b weight x4, c weight x2.
    int weight [3] = '{1, 4, 2};

    always #5 clk_sys = ~clk_sys;

    audio_mix_sdac_if #(.NCH(3), .IN_W(8), .OUT_W(11)) bus_a ();
    audio_mix_sdac_if #(.NCH(3), .IN_W(8), .OUT_W(10)) bus_b ();

    assign bus_b.ce_sample = bus_a.ce_sample;
    assign bus_b.ch_in     = bus_a.ch_in;
    assign bus_b.ch_mute   = bus_a.ch_mute;
    assign bus_b.clr_flags = bus_a.clr_flags;

    audio_mix_sdac #(.NCH(3), .IN_W(8), .OUT_W(11), .CH_SHIFT({3'd1, 3'd2, 3'd0})) dut_a (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_a.slave)
    );

    audio_mix_sdac #(.NCH(3), .IN_W(8), .OUT_W(10), .CH_SHIFT({3'd1, 3'd2, 3'd0})) dut_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus_b.slave)
    );

    function automatic int model_sum(input logic [23:0] ch, input logic [2:0] mute);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++) begin
            if (!mute[i]) s += int'(ch[8*i +: 8]) * weight[i];
        end
        return s;
    endfunction

    function automatic int model_sat(input int s, input int out_w);
        int mx;
        mx = (1 << out_w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_flags();
        bus_a.clr_flags = 1'b1;
        step();
        bus_a.clr_flags = 1'b0;
        clip_a_m = 1'b0;
        clip_b_m = 1'b0;
        ovr_m    = 1'b0;
        check("clr_clip_a", 32'(bus_a.clip), 32'(clip_a_m));
        check("clr_clip_b", 32'(bus_b.clip), 32'(clip_b_m));
        check("clr_ovr_a",  32'(bus_a.overrun), 32'(ovr_m));
    endtask

    // One complete mix: strobe, scramble inputs in flight, check timing and result.
    task automatic run_mix(input logic [23:0] ch, input logic [2:0] mute,
                           input logic [23:0] ch_after, input string tag);
        int s;
        s = model_sum(ch, mute);
        bus_a.ch_in     = ch;
        bus_a.ch_mute   = mute;
        bus_a.ce_sample = 1'b1;
        step();
        bus_a.ce_sample = 1'b0;
        bus_a.ch_in     = ch_after;
        bus_a.ch_mute   = ~mute;
        for (int k = 1; k <= NCH; k++) begin
            check({tag, "_busy"},  32'(bus_a.busy), 32'd1);
            check({tag, "_early"}, 32'(bus_a.mix_valid), 32'd0);
            step();
        end
        if (s > 2047) clip_a_m = 1'b1;
        if (s > 1023) clip_b_m = 1'b1;
        check({tag, "_valid_a"}, 32'(bus_a.mix_valid), 32'd1);
        check({tag, "_out_a"},   32'(bus_a.mix_out), 32'(model_sat(s, 11)));
        check({tag, "_idle_a"},  32'(bus_a.busy), 32'd0);
        check({tag, "_clip_a"},  32'(bus_a.clip), 32'(clip_a_m));
        check({tag, "_valid_b"}, 32'(bus_b.mix_valid), 32'd1);
        check({tag, "_out_b"},   32'(bus_b.mix_out), 32'(model_sat(s, 10)));
        check({tag, "_clip_b"},  32'(bus_b.clip), 32'(clip_b_m));
        check({tag, "_ovr_a"},   32'(bus_a.overrun), 32'(ovr_m));
        step();
        check({tag, "_pulse_a"}, 32'(bus_a.mix_valid), 32'd0);
    endtask

    task automatic count_dac(input int n, output int ones_a, output int ones_b);
        ones_a = 0;
        ones_b = 0;
        for (int k = 0; k < n; k++) begin
            step();
            ones_a += int'(bus_a.dac_o);
            ones_b += int'(bus_b.dac_o);
        end
    endtask

    initial begin
        int s;
        int oa;
        int ob;
        logic [23:0] ch2;

        bus_a.ce_sample = 1'b0;
        bus_a.ch_in     = 24'h000000;
        bus_a.ch_mute   = 3'b000;
        bus_a.clr_flags = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_out",   32'(bus_a.mix_out), 32'd0);
        check("rst_valid", 32'(bus_a.mix_valid), 32'd0);
        check("rst_busy",  32'(bus_a.busy), 32'd0);
        check("rst_clip",  32'(bus_a.clip), 32'd0);
        check("rst_ovr",   32'(bus_a.overrun), 32'd0);
        check("rst_dac",   32'(bus_a.dac_o), 32'd0);
        check("rst_out_b", 32'(bus_b.mix_out), 32'd0);
        reset = 1'b0;
        step();

        // Full scale: 1785 fits 11 bits, saturates at 1023 in 10 bits
        run_mix(24'hFFFFFF, 3'b000, 24'hFFFFFF, "full");
        clear_flags();
        run_mix(24'h00000A, 3'b110, 24'hFFFFFF, "a10");

        // Muted channel b, inputs zeroed right after the strobe
        run_mix(24'hFFFFFF, 3'b010, 24'h000000, "mute");

        // Strobe during accumulation sets overrun; strobe in DONE is accepted
        s = model_sum(24'h123456, 3'b000);
        bus_a.ch_in = 24'h123456; bus_a.ch_mute = 3'b000; bus_a.ce_sample = 1'b1;
        step();
        bus_a.ce_sample = 1'b0;
        step();
        bus_a.ce_sample = 1'b1;
        step();
        bus_a.ce_sample = 1'b0;
        ovr_m = 1'b1;
        check("ovr_set_a", 32'(bus_a.overrun), 32'(ovr_m));
        check("ovr_set_b", 32'(bus_b.overrun), 32'(ovr_m));
        check("ovr_novalid", 32'(bus_a.mix_valid), 32'd0);
        bus_a.clr_flags = 1'b1;
        step();
        bus_a.clr_flags = 1'b0;
        ovr_m = 1'b0;
        check("ovr_valid", 32'(bus_a.mix_valid), 32'd1);
        check("ovr_out",   32'(bus_a.mix_out), 32'(model_sat(s, 11)));
        check("ovr_clr",   32'(bus_a.overrun), 32'(ovr_m));
        ch2 = 24'h0A0B0C;
        bus_a.ch_in = ch2; bus_a.ce_sample = 1'b1;
        step();
        bus_a.ce_sample = 1'b0;
        check("done_accept", 32'(bus_a.busy), 32'd1);
        check("done_noovr",  32'(bus_a.overrun), 32'(ovr_m));
        check("done_single", 32'(bus_a.mix_valid), 32'd0);
        repeat (3) step();
        check("done_valid", 32'(bus_a.mix_valid), 32'd1);
        check("done_out",   32'(bus_a.mix_out), 32'(model_sat(model_sum(ch2, 3'b000), 11)));
        check("done_ovr",   32'(bus_a.overrun), 32'(ovr_m));
        step();

        // Reset in the middle of accumulation discards the mix
        bus_a.ch_in = 24'hFFFFFF; bus_a.ce_sample = 1'b1;
        step();
        bus_a.ce_sample = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clip_a_m = 1'b0; clip_b_m = 1'b0; ovr_m = 1'b0;
        check("mrst_busy", 32'(bus_a.busy), 32'd0);
        check("mrst_out",  32'(bus_a.mix_out), 32'd0);
        check("mrst_clip", 32'(bus_b.clip), 32'd0);
        oa = 0;
        for (int k = 0; k < 6; k++) begin
            oa += int'(bus_a.mix_valid) + int'(bus_b.mix_valid);
            step();
        end
        check("mrst_novalid", 32'(oa), 32'd0);
        run_mix(24'h40C020, 3'b000, 24'h000000, "post_rst");

        // Randomized mixes against the model
        for (int i = 0; i < 16; i++) begin
            if (i == 8) clear_flags();
            run_mix(24'($urandom), 3'($urandom_range(0, 7)), 24'($urandom), "rnd");
        end

        // Sigma-delta density: a=4, b=FF -> 1024 (a), 1023 saturated (b)
        run_mix(24'h00FF04, 3'b000, 24'h000000, "sd");
        repeat (2048) step();
        count_dac(2048, oa, ob);
        check("sd_ones_a", 32'(oa), 32'(1024 * 2048 / 2048));
        check("sd_ones_b", 32'(ob), 32'(1023 * 2048 / 1024));

        // Zero mix gives a silent bitstream
        run_mix(24'h000000, 3'b111, 24'hFFFFFF, "zero");
        repeat (4) step();
        count_dac(64, oa, ob);
        check("sd_zero_a", 32'(oa), 32'd0);
        check("sd_zero_b", 32'(ob), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_mix_sdac.md
Name: audio_mix_sdac

Overview:
- Parametrised successor to the fixed three-channel sum plus `dac` used in the arcade tops.
- Mixes NCH unsigned sound channels. Each channel has a per-channel power-of-two weight and a runtime mute.
- Channels are accumulated sequentially, one per clock, and the result saturates to OUT_W bits.
- A built-in first-order sigma-delta modulator drives a 1-bit audio pin. Sits between the core's sound outputs and AUDIO_L/AUDIO_R.

Parameters:
- NCH, 3: number of input channels, 1..16.
- IN_W, 8: width of each channel sample, unsigned.
- OUT_W, 11: width of the mixed sample and of the DAC input.
- CH_SHIFT, {3'd1,3'd2,3'd0}: packed NCH*3 bits. Left shift for channel i is CH_SHIFT[3i+2:3i], range 0..7.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_sample  in  1  one-cycle strobe that starts a new mix.
- ch_in  in  NCH*IN_W  channel samples; channel i is at [IN_W*i +: IN_W].
- ch_mute  in  NCH  bit i=1 excludes channel i from the mix.
- mix_out  out  OUT_W  last completed, saturated mix.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high while accumulating.
- clip  out  1  sticky: set when any mix saturated.
- overrun  out  1  sticky: set when ce_sample arrives while busy.
- clr_flags  in  1  clears clip and overrun.
- dac_o  out  1  sigma-delta bitstream.

Behaviour:
- Reset values: mix_out=0, mix_valid=0, busy=0, clip=0, overrun=0, dac_o=0. Internal sigma-delta accumulator=0, FSM in IDLE.
- Reset wins over every other input in the same cycle. Reset mid-accumulation discards the partial sum, and mix_out keeps its reset value of 0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: on ce_sample, snapshot ch_in and ch_mute into registers, clear sum, set idx=0, go to ACCUM. busy=1 from the next cycle.
- ACCUM: each cycle, if the snapshot mute bit for channel idx is 0, add (snapshot ch[idx] << shift[idx]) to sum.
  - idx increments each cycle. After idx=NCH-1, go to DONE.
  - sum width is IN_W+7+clog2(NCH)+1 bits, so it never wraps internally.
- DONE:
  - If sum > 2^OUT_W-1: mix_out = 2^OUT_W-1 and clip is set. Otherwise mix_out = sum[OUT_W-1:0].
  - mix_valid pulses this cycle and the state returns to IDLE next cycle.
  - busy=0 in DONE, so a ce_sample in DONE is treated as IDLE and is accepted next cycle.
- Latency: ce_sample at cycle 0 gives mix_valid and the new mix_out at cycle NCH+1.
- ce_sample while in ACCUM: the strobe is ignored and overrun is set. The current mix completes unaffected.
- ch_in and ch_mute changes after the snapshot do not affect the mix in flight.
- clr_flags clears clip and overrun. If a set event and clr_flags occur in the same cycle, set wins.
- Sigma-delta runs every clock, independent of the FSM:
  - acc (OUT_W+1 bits) <= {1'b0, acc[OUT_W-1:0]} + mix_out.
  - dac_o <= acc[OUT_W] (registered).
  - Density of ones = mix_out / 2^OUT_W. mix_out=0 gives constant 0; mix_out=2^OUT_W-1 gives one 0 per 2^OUT_W clocks.
- Elaboration checks: NCH=0 or OUT_W<IN_W is an elaboration error.

Decomposition:
- Shared package audio_pkg:
  - FSM state typedef mix_state_t {IDLE, ACCUM, DONE}.
  - Function sat_u(value, width).
  - Constant SHIFT_W=3.
- One sub-module sigma_delta_dac (params W; ports clk_sys, reset, din[W], dout). It is natural to reuse on other cores.
- The mixer FSM stays in audio_mix_sdac.

Test Plan:
- Defaults, ch_in {c=FF, b=FF, a=FF}, mute=0, ce_sample pulse → mix_valid at cycle 4, mix_out=1785 (255 + 1020 + 510), clip=0.
- OUT_W=10, same stimulus → mix_out=1023, clip=1. clr_flags → clip=0. Next mix of a=10 only → mix_out=10, clip stays 0.
- Defaults, ch_mute=3'b010, all channels FF → mix_out=765. Change ch_in to 00 one cycle after ce_sample → mix_out still 765.
- ce_sample at cycles 0 and 2 → one mix_valid at cycle 4, overrun=1. ce_sample at cycle 4 (DONE) → accepted, no additional overrun.
- Hold mix_out=1024 (OUT_W=11) → exactly 1024 ones in any 2048-clock window after the first 2048 clocks. mix_out=0 → dac_o constant 0.
- Assert reset at cycle 2 of ACCUM → mix_out=0, busy=0, no mix_valid. Next ce_sample produces a correct mix.
